canny_frame_ctrl: RTL and testbench

Frame-level controller placed in front of the Canny edge-detection pipeline (gradient → non-max suppression → double threshold). It admits or blocks whole frames into the pipeline and shadows the threshold and bypass configuration, committing it only at frame start. It also measures the geometry of every admitted frame against the nominal size and reports frame completion once the pipeline has drained.

---
 rtl/canny_pkg.sv | 18 +
 rtl/canny_frame_ctrl_if.sv | 21 ++
 rtl/canny_frame_meter.sv | 51 +++++
 rtl/canny_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_canny_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/canny_pkg.sv
// Shared types and defaults for the Canny frame controller slice.
package canny_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE,
    DRAIN
  } state_t;

  localparam int unsigned ERR_PIX  = 0;
  localparam int unsigned ERR_LINE = 1;

  localparam int unsigned DEF_IMG_WIDTH    = 640;
  localparam int unsigned DEF_IMG_HEIGHT   = 480;
  localparam int unsigned DEF_DRAIN_CYCLES = 2 * DEF_IMG_WIDTH + 16;

endpackage

// File: rtl/canny_frame_ctrl_if.sv
// Frame sync bundle: raw input timing in, gated timing out to the pipeline.
interface canny_frame_ctrl_if;

  logic per_frame_vsync;
  logic per_frame_href;
  logic per_frame_clken;
  logic pipe_frame_vsync;
  logic pipe_frame_href;
  logic pipe_frame_clken;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    input  pipe_frame_vsync, pipe_frame_href, pipe_frame_clken
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    output pipe_frame_vsync, pipe_frame_href, pipe_frame_clken
  );

endinterface

// File: rtl/canny_frame_meter.sv
// Pixel/line counters of an admitted frame and the sticky geometry error flags.
module canny_frame_meter
  import canny_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic       clk,
  input  logic       rst_s,
  input  logic       clear,
  input  logic       active,
  input  logic       pix_inc,
  input  logic       line_end,
  input  logic       frame_end,
  output logic [1:0] frame_err
);

  localparam int unsigned PIX_W  = $clog2(IMG_WIDTH + 1);
  localparam int unsigned LINE_W = $clog2(IMG_HEIGHT + 1);

  logic [PIX_W-1:0]  pix_cnt, pix_next;
  logic [LINE_W-1:0] line_cnt, line_next;

  // Saturating next values; the line-end check sees a pixel arriving in the same cycle.
  always_comb begin
    pix_next  = pix_cnt;
    line_next = line_cnt;
    if (pix_inc && (pix_cnt != '1)) pix_next = pix_cnt + PIX_W'(1);
    if (line_end && (line_cnt != '1)) line_next = line_cnt + LINE_W'(1);
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_err <= '0;
    end else if (clear) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_err <= '0;
    end else if (active) begin
      pix_cnt  <= line_end ? '0 : pix_next;
      line_cnt <= line_next;
      if (line_end && (pix_next != PIX_W'(IMG_WIDTH)))
        frame_err[ERR_PIX] <= 1'b1;
      if (frame_end && (line_next != LINE_W'(IMG_HEIGHT)))
        frame_err[ERR_LINE] <= 1'b1;
    end
  end

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame admission, shadowed threshold commit and drain tracking in front of
// the Canny pipeline.
module canny_frame_ctrl
  import canny_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int unsigned THR_WIDTH    = 8,
  parameter int unsigned DRAIN_CYCLES = 2 * IMG_WIDTH + 16
) (
  input  logic                 clk,
  input  logic                 rst_s,
  input  logic                 cfg_wr,
  input  logic [THR_WIDTH-1:0] cfg_high_thr,
  input  logic [THR_WIDTH-1:0] cfg_low_thr,
  input  logic                 cfg_bypass,
  input  logic                 cfg_enable,
  canny_frame_ctrl_if.slave    pix,
  output logic [THR_WIDTH-1:0] act_high_thr,
  output logic [THR_WIDTH-1:0] act_low_thr,
  output logic                 act_bypass,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic [1:0]           frame_err
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  state_t               state, state_next;
  logic                 vs_d, hs_d;
  logic                 vs_rise, vs_fall, hs_fall;
  logic                 commit, load_drain, gate;
  logic [DW-1:0]        drain_cnt;
  logic [THR_WIDTH-1:0] sh_high, sh_low;
  logic                 sh_bypass;

  assign vs_rise = pix.per_frame_vsync & ~vs_d;
  assign vs_fall = ~pix.per_frame_vsync & vs_d;
  assign hs_fall = ~pix.per_frame_href & hs_d;
  assign gate    = (state == ACTIVE) || commit;

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    load_drain = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: if (cfg_enable) state_next = WAIT_VS;
      WAIT_VS: begin
        if (!cfg_enable) begin
          state_next = IDLE;
        end else if (vs_rise) begin
          commit     = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vs_fall) begin
          load_drain = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // A new frame cuts the drain short so back-to-back frames are not lost.
        if (vs_rise) begin
          frame_done = 1'b1;
          commit     = 1'b1;
          state_next = ACTIVE;
        end else if (drain_cnt == '0) begin
          frame_done = 1'b1;
          state_next = cfg_enable ? WAIT_VS : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state     <= IDLE;
      vs_d      <= 1'b0;
      hs_d      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state <= state_next;
      vs_d  <= pix.per_frame_vsync;
      hs_d  <= pix.per_frame_href;
      if (load_drain)
        drain_cnt <= DW'(DRAIN_CYCLES - 1);
      else if ((state == DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      pix.pipe_frame_vsync <= 1'b0;
      pix.pipe_frame_href  <= 1'b0;
      pix.pipe_frame_clken <= 1'b0;
    end else begin
      pix.pipe_frame_vsync <= gate & pix.per_frame_vsync;
      pix.pipe_frame_href  <= gate & pix.per_frame_href;
      pix.pipe_frame_clken <= gate & pix.per_frame_clken;
    end
  end

  // Commit reads the shadow before a coincident cfg_wr lands in it.
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      sh_high      <= '0;
      sh_low       <= '0;
      sh_bypass    <= 1'b0;
      act_high_thr <= '0;
      act_low_thr  <= '0;
      act_bypass   <= 1'b0;
      frame_busy   <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_high   <= cfg_high_thr;
        sh_low    <= cfg_low_thr;
        sh_bypass <= cfg_bypass;
      end
      if (commit) begin
        act_high_thr <= sh_high;
        act_low_thr  <= (sh_low > sh_high) ? sh_high : sh_low;
        act_bypass   <= sh_bypass;
      end
      if (commit)
        frame_busy <= 1'b1;
      else if (frame_done)
        frame_busy <= 1'b0;
    end
  end

  canny_frame_meter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_meter (
    .clk      (clk),
    .rst_s    (rst_s),
    .clear    (commit),
    .active   (state == ACTIVE),
    .pix_inc  (pix.per_frame_clken & pix.per_frame_href),
    .line_end (hs_fall | (vs_fall & pix.per_frame_href)),
    .frame_end(vs_fall),
    .frame_err(frame_err)
  );

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed bench for canny_frame_ctrl on an 8x4 frame with a 20-cycle drain.
module tb_canny_frame_ctrl;
  import canny_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned D  = 20;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rst_s;
  logic          cfg_wr;
  logic [TW-1:0] cfg_high_thr, cfg_low_thr;
  logic          cfg_bypass, cfg_enable;
  logic [TW-1:0] act_high_thr, act_low_thr;
  logic          act_bypass, frame_busy, frame_done;
  logic [1:0]    frame_err;

  canny_frame_ctrl_if bus ();

  canny_frame_ctrl #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .THR_WIDTH   (TW),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk         (clk),
    .rst_s       (rst_s),
    .cfg_wr      (cfg_wr),
    .cfg_high_thr(cfg_high_thr),
    .cfg_low_thr (cfg_low_thr),
    .cfg_bypass  (cfg_bypass),
    .cfg_enable  (cfg_enable),
    .pix         (bus),
    .act_high_thr(act_high_thr),
    .act_low_thr (act_low_thr),
    .act_bypass  (act_bypass),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic          pv = 1'b0, ph = 1'b0, pc = 1'b0;
  bit            admit = 1'b0;
  logic [TW-1:0] exp_hi = '0, exp_lo = '0;
  logic          exp_byp = 1'b0;
  logic [1:0]    last_err = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check at the falling edge.
  task automatic step(input logic v, input logic h, input logic c, input logic w);
    @(posedge clk);
    #1;
    bus.per_frame_vsync = v;
    bus.per_frame_href  = h;
    bus.per_frame_clken = c;
    cfg_wr              = w;
    @(negedge clk);
    chk("pipe_vsync", 32'(bus.pipe_frame_vsync), 32'(admit ? pv : 1'b0));
    chk("pipe_href",  32'(bus.pipe_frame_href),  32'(admit ? ph : 1'b0));
    chk("pipe_clken", 32'(bus.pipe_frame_clken), 32'(admit ? pc : 1'b0));
    pv = v; ph = h; pc = c;
  endtask

  task automatic chk_act(input string tag);
    chk({tag, "_high"}, 32'(act_high_thr), 32'(exp_hi));
    chk({tag, "_low"},  32'(act_low_thr),  32'(exp_lo));
    chk({tag, "_byp"},  32'(act_bypass),   32'(exp_byp));
  endtask

  task automatic frame_start(input bit adm, input logic wr_rise, input logic exp_done);
    admit = adm;
    step(1'b1, 1'b0, 1'b0, wr_rise);
    chk("done_at_rise", 32'(frame_done), 32'(exp_done));
    chk("busy_at_rise", 32'(frame_busy), 32'(exp_done));
    chk("err_held",     32'(frame_err),  32'(last_err));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    if (adm) begin
      chk_act("act_commit");
      chk("busy_commit", 32'(frame_busy), 32'd1);
      chk("err_cleared", 32'(frame_err),  32'd0);
    end else begin
      chk("busy_blocked", 32'(frame_busy), 32'd0);
    end
  endtask

  task automatic frame_body(input int nlines, input int bad_line, input bit wr_mid);
    for (int l = 0; l < nlines; l++) begin
      int npix;
      npix = (l == bad_line) ? int'(W) - 1 : int'(W);
      for (int p = 0; p < npix; p++)
        step(1'b1, 1'b1, 1'b1, logic'(wr_mid && (l == 1) && (p == 0)));
      step(1'b1, 1'b0, 1'b1, 1'b0);  // clken outside href must not count
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    if (admit) chk_act("act_stable");
  endtask

  task automatic drain(input int n, input logic [1:0] eerr);
    for (int i = 1; i <= n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 1) chk("frame_err", 32'(frame_err), 32'(eerr));
      chk("done_early", 32'(frame_done), 32'd0);
    end
    last_err = eerr;
  endtask

  task automatic wait_done(input logic [1:0] eerr);
    drain(int'(D) - 1, eerr);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("busy_at_done", 32'(frame_busy), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_after", 32'(frame_done), 32'd0);
    chk("busy_after", 32'(frame_busy), 32'd0);
  endtask

  task automatic write_cfg(input logic [TW-1:0] hi, input logic [TW-1:0] lo, input logic byp);
    cfg_high_thr = hi;
    cfg_low_thr  = lo;
    cfg_bypass   = byp;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pvs"},  32'(bus.pipe_frame_vsync), 32'd0);
    chk({tag, "_phs"},  32'(bus.pipe_frame_href),  32'd0);
    chk({tag, "_pce"},  32'(bus.pipe_frame_clken), 32'd0);
    chk({tag, "_hi"},   32'(act_high_thr), 32'd0);
    chk({tag, "_lo"},   32'(act_low_thr),  32'd0);
    chk({tag, "_byp"},  32'(act_bypass),   32'd0);
    chk({tag, "_busy"}, 32'(frame_busy),   32'd0);
    chk({tag, "_done"}, 32'(frame_done),   32'd0);
    chk({tag, "_err"},  32'(frame_err),    32'd0);
  endtask

  initial begin
    rst_s = 1'b1;
    cfg_wr = 1'b0;
    cfg_enable = 1'b0;
    write_cfg(8'd0, 8'd0, 1'b0);
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_s = 1'b0;

    // Admit and drain a nominal frame
    write_cfg(8'd100, 8'd20, 1'b1);
    cfg_enable = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_commit_yet", 32'(act_high_thr), 32'd0);
    exp_hi = 8'd100; exp_lo = 8'd20; exp_byp = 1'b1;
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);

    // Mid-frame write holds until the next frame
    write_cfg(8'd200, 8'd50, 1'b0);
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b1);
    wait_done(2'b00);
    exp_hi = 8'd200; exp_lo = 8'd50; exp_byp = 1'b0;
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);

    // Low above high clamps to high
    write_cfg(8'd60, 8'd90, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp_hi = 8'd60; exp_lo = 8'd60; exp_byp = 1'b0;
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);

    // Write coincident with vs_rise commits the old shadow
    write_cfg(8'd150, 8'd30, 1'b1);
    frame_start(1'b1, 1'b1, 1'b0);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);
    exp_hi = 8'd150; exp_lo = 8'd30; exp_byp = 1'b1;
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);

    // Bad geometry, then recovery
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, 2, 1'b0);
    wait_done(2'b01);
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H - 1, -1, 1'b0);
    wait_done(2'b10);
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);

    // Enable rising mid-frame skips that frame
    cfg_enable = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    admit = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cfg_enable = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    chk("blocked_busy", 32'(frame_busy), 32'd0);
    drain(3, 2'b00);
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);

    // Enable dropped during ACTIVE: frame completes, FSM idles
    frame_start(1'b1, 1'b0, 1'b0);
    cfg_enable = 1'b0;
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);
    chk("state_idle", 32'(dut.state), 32'(IDLE));

    // Back-to-back: vs_rise during DRAIN
    cfg_enable = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    drain(5, 2'b00);
    frame_start(1'b1, 1'b0, 1'b1);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);

    // Reset mid-frame, then the next full frame is admitted
    frame_start(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < int'(W); p++) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    rst_s = 1'b1;
    #1;
    chk_all_zero("midreset");
    admit = 1'b0; pv = 1'b0; ph = 1'b0; pc = 1'b0;
    #2;
    rst_s = 1'b0;
    for (int p = 1; p < int'(W); p++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < int'(W); p++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_frame_busy", 32'(frame_busy), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_hi = 8'd0; exp_lo = 8'd0; exp_byp = 1'b0;
    last_err = 2'b00;
    frame_start(1'b1, 1'b0, 1'b0);
    frame_body(H, -1, 1'b0);
    wait_done(2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
